// File: rtl/maxpool_2x2_if.sv
// ============================================================================
//  Module      : maxpool_2x2_if
//  Description : Input and output valid/ready sample streams of the 2x2
//                max-pooling stage. The slave modport is the pooling block.
//                The master modport is the environment that feeds it and
//                drains it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface maxpool_2x2_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/maxpool_2x2.sv
// ============================================================================
//  Module      : maxpool_2x2
//  Description : Streaming 2x2 / stride-2 signed max-pooling stage.
//                - Consumes one raster-order frame after a pool_enable pulse.
//                - Emits (IMG_W/2)x(IMG_H/2) pooled samples.
//                - Pulses done when the last pooled sample has been taken.
//                Even-row pair maxima wait in a half-row line buffer until
//                the odd row arrives.
//                Optional macro MAXPOOL_RELU_EN: the pooled value is clamped
//                to a floor of 0, which fuses ReLU into this stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_2x2 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          pool_enable,
    maxpool_2x2_if.slave       bus,
    output logic               busy,
    output logic               done
);

    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [COL_W-1:0]          r_col;
    logic [ROW_W-1:0]          r_row;
    logic signed [DATA_W-1:0]  r_pmax;
    logic signed [DATA_W-1:0]  r_lbuf [LB_DEPTH];
    logic signed [DATA_W-1:0]  r_out_data;
    logic                      r_out_valid;

    logic                      w_in_ready;
    logic                      w_in_hs;
    logic                      w_out_hs;
    logic                      w_last_px;
    logic [LB_AW-1:0]          w_lb_idx;
    logic signed [DATA_W-1:0]  w_in_data;
    logic signed [DATA_W-1:0]  w_lb_rd;
    logic signed [DATA_W-1:0]  w_pair_max;
    logic signed [DATA_W-1:0]  w_quad_max;
    logic signed [DATA_W-1:0]  w_pooled;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Input is stalled only while a pooled sample is pending and refused.
    assign w_in_ready = (r_state == ST_RUN) && !(r_out_valid && !bus.out_ready);
    assign w_in_hs    = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;
    assign w_last_px  = (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);

    assign w_in_data  = $signed(bus.in_data);
    assign w_lb_idx   = LB_AW'(r_col >> 1);
    assign w_lb_rd    = r_lbuf[w_lb_idx];
    assign w_pair_max = smax(r_pmax, w_in_data);
    assign w_quad_max = smax(w_lb_rd, w_pair_max);

`ifdef MAXPOOL_RELU_EN
    assign w_pooled = w_quad_max[DATA_W-1] ? '0 : w_quad_max;
`else
    assign w_pooled = w_quad_max;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pool_enable) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_in_hs && w_last_px) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_out_hs) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Raster position counters; cleared while idle, advanced per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == ST_IDLE) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_hs) begin
            if (r_col == C_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == C_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Pair register holds the even-column sample of the current pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmax <= '0;
        end else if (w_in_hs && !r_col[0]) begin
            r_pmax <= w_in_data;
        end
    end

    // Line buffer: even-row pair maxima. Never cleared; each entry is
    // rewritten on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_in_hs && !r_row[0] && r_col[0]) begin
            r_lbuf[w_lb_idx] <= w_pair_max;
        end
    end

    // Output register; a new sample may load in the same cycle the previous one is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_hs && r_row[0] && r_col[0]) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_pooled;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: doc/maxpool_2x2.md
# maxpool_2x2

Streaming 2x2/stride-2 max-pooling stage, the consumer of the control unit's `pool_enable` pulse in the YOLO pipeline. It accepts one convolution-output frame in raster order on a valid/ready input stream. It emits the pooled frame, (IMG_W/2)x(IMG_H/2) signed samples, on a valid/ready output stream. It then pulses `done` so the controller can advance to the activation stage. A half-row line buffer holds the pairwise maxima of each even row until the matching odd row arrives.

## Interface
- `DATA_W`, 8: signed sample width.
- `IMG_W`, 8: input frame width in pixels; even, ≥2.
- `IMG_H`, 8: input frame height in pixels; even, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pool_enable`  in  1  start pulse; sampled only in IDLE.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept the input sample.
- `in_data`  in  DATA_W  signed input sample, raster order.
- `out_valid`  out  1  pooled sample valid.
- `out_ready`  in  1  downstream accepts the pooled sample.
- `out_data`  out  DATA_W  signed pooled sample.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse after the last pooled sample is taken.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `pool_enable`=1 → RUN.
  - Column counter `col` and row counter `row` are cleared to 0.
- **RUN:** an input handshake occurs when `in_valid && in_ready`. On each handshake:
  - `col` increments and wraps at IMG_W-1.
  - On wrap, `row` increments.
- **Even `row`:**
  - Even `col`: latch the sample into the pair register `pmax`.
  - Odd `col`: write `max(pmax, in_data)` to `lbuf[col>>1]`.
- **Odd `row`:**
  - Even `col`: latch the sample into `pmax`.
  - Odd `col`: load `max(lbuf[col>>1], pmax, in_data)` into the output register and set `out_valid`.
- **Comparisons:** all are signed two's-complement. On equal values either operand may be selected, since the result is identical. No width growth: output width is DATA_W.
- **Leaving RUN:** the handshake at `row`=IMG_H-1, `col`=IMG_W-1 moves to DRAIN.
- **DRAIN:** wait for the output handshake `out_valid && out_ready`, then go to DONE.
- **DONE:**
  - Assert `done` for one cycle.
  - Go to IDLE.
- `pool_enable` in RUN, DRAIN or DONE is ignored and is not queued.
- Line buffer size is IMG_W/2 entries of DATA_W bits. It is not cleared between frames; every entry is rewritten before it is read.

## Timing
- **Reset values:** `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, state=IDLE, counters=0.
- **`in_ready`:** equals `(state==RUN) && !(out_valid && !out_ready)`. The block stalls input only while a pooled sample is pending and refused.
- **Output register:** a pooled sample can be loaded in the same cycle the previous one is handshaked. This gives full throughput of 1 input sample per cycle.
- **Latency:** `out_valid` rises the cycle after the input handshake of the odd-row, odd-column pixel. `out_data` is held stable while `out_valid && !out_ready`.
- **Start:** with `pool_enable` at cycle N, `in_ready` and `busy` are high at N+1.
- **End:** with the final output handshake at cycle M, `done`=1 and `busy`=0 at M+1, and state is IDLE at M+2.
- **Reset mid-frame:** returns to IDLE at once. A pending output is discarded and `out_valid` goes to 0 asynchronously. No `done` is produced.
- **Input stalls:** deasserting `in_valid` at any point freezes all state.

## Configuration
- `MAXPOOL_RELU_EN` defined: the pooled value is clamped to a floor of 0 before loading the output register, so negative results emit 0. This fuses ReLU into the stage.
- `MAXPOOL_RELU_EN` undefined: the signed maximum is passed unmodified.
- Timing and handshakes are identical in both builds.

## Test plan
- **Basic frame:** IMG_W=IMG_H=4, pulse `pool_enable`, feed 0..15 with `in_valid` held high and `out_ready`=1.
  - Outputs are 5, 7, 13, 15.
  - `done` pulses once, 1 cycle after the handshake of 15.
- **Signed data:** same frame with all samples = -k (0..-15).
  - Without macro: outputs are 0, -2, -8, -10.
  - With `MAXPOOL_RELU_EN`: outputs are 0, 0, 0, 0.
- **Backpressure:** basic frame with `out_ready` low for 5 cycles after the first `out_valid`.
  - `out_data`=5 is held and `in_ready`=0 during the stall.
  - The sequence is unchanged and no samples are lost or duplicated.
- **Spurious start:** `pool_enable` pulsed at input sample 6 of the basic frame.
  - Sequence and `done` count are unchanged.
  - The block returns to IDLE and waits for a new pulse.
- **Reset mid-frame:** assert `rst_n`=0 after 9 input samples.
  - All outputs are 0 the same cycle and no `done` is produced.
  - A following full frame of 15..0 yields 15, 13, 7, 5.
- **Default size:** IMG_W=IMG_H=8, random `in_valid` and `out_ready`.
  - 16 outputs match the reference model.
  - `done` pulses exactly once per frame.
